ball_engine: RTL and testbench
==============================

Name: ball_engine

Overview:
- Game-state stage directly upstream of the VGA compositor; produces the ball_x/ball_y it draws.
- Takes both player centre positions, advances the ball once per frame tick, resolves wall, player and goal collisions, and keeps score.
- All coordinates are in 320x240 half-resolution pixel space, ball-centre referenced.

Parameters:
FIELD_W, 320, field width in pixels
FIELD_H, 240, field height in pixels
BALL_R, 25, ball radius; wall limits are BALL_R and FIELD_x-1-BALL_R
HIT_DIST_SQ, 2809, squared centre distance at or below which a player hits the ball
SPEED, 2, per-axis velocity magnitude, pixels/tick
GOAL_Y_MIN, 80, lowest ball_y counted as inside a goal mouth
GOAL_Y_MAX, 160, highest ball_y counted as inside a goal mouth
SERVE_FRAMES, 60, ticks the ball rests at centre before play
GOAL_FRAMES, 30, ticks the ball is frozen after a goal
WIN_SCORE, 7, score that ends the game

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
frame_tick  in  1  one-cycle pulse, once per video frame
p1_x, p1_y, p2_x, p2_y  in  16 each  player centres
ball_x, ball_y  out  16 each  ball centre, registered
score_p1, score_p2  out  4 each  scores
goal  out  1  one-cycle pulse when a goal is scored
update_done  out  1  one-cycle pulse after each position update
game_over  out  1  level, high once a score reaches WIN_SCORE

Behaviour:
- Reset (rst==0 sampled at a clk edge):
  - ball=(160,120); vx=+SPEED, vy=-SPEED; scores 0.
  - goal=update_done=game_over=0; tick counter 0; state SERVE.
- States: SERVE, WAIT, HIT_P1, HIT_P2, MOVE, GOAL, OVER.
- frame_tick is sampled only in SERVE, WAIT and GOAL. Ticks arriving in HIT_P1/HIT_P2/MOVE/OVER are dropped, not queued.
- SERVE: ball held at centre, counter counts ticks. The SERVE_FRAMES-th tick clears the counter and enters WAIT. No move happens on that tick.
- WAIT -> HIT_P1 on tick.
- HIT_P1: registers the p1 hit flag. dx/dy are 17-bit signed differences (ball - player); dx^2+dy^2 is formed unsigned at 34 bits; hit if <= HIT_DIST_SQ.
- HIT_P2: same test for p2.
- Hit response: vx=+SPEED if ball_x>=p_x else -SPEED; vy=+SPEED if ball_y>=p_y else -SPEED. If both players hit, p1 wins.
- MOVE: nx=ball_x+vx, ny=ball_y+vy, using post-hit velocity.
  - Top: if ny<BALL_R, then ny=BALL_R and vy=+|vy|.
  - Bottom: if ny>FIELD_H-1-BALL_R, clamp and vy=-|vy|.
  - Left: if nx<BALL_R, the goal test uses the clamped ny, inclusive window. Inside the window: p2 scores. Outside: nx=BALL_R, vx=+|vx|.
  - Right: if nx>FIELD_W-1-BALL_R, same rule. Inside the window: p1 scores. Outside: clamp, vx=-|vx|.
  - Write ball_x/ball_y, then update_done=1 for the next cycle. Total latency is 3 clk edges after the tick-sampling edge.
  - Next state: WAIT, or GOAL on a goal, or OVER if the incremented score == WIN_SCORE.
- Goal:
  - Ball is written at its clamped wall position; goal pulses 1 cycle alongside update_done; score increments.
  - Scores never exceed WIN_SCORE.
  - GOAL holds the ball for GOAL_FRAMES ticks, then re-centres it. Serve is toward the conceding side: vx=+SPEED if p1 scored, else -SPEED; vy=-SPEED. Then enters SERVE.
- OVER: game_over=1, outputs frozen until reset.
- Reset mid-update (any state) wins over all other activity that edge.

Optional Feature:
SPEEDUP_EN
- Defined: each player hit raises the velocity magnitude by 1, saturating at 2*SPEED. The magnitude returns to SPEED on every serve and on reset.
- Undefined: the magnitude is always SPEED.

Test Plan:
- Reset, then 60 ticks -> ball stays (160,120), no update_done. Tick 61 -> ball (162,118) exactly 3 edges later, update_done 1 cycle.
- Players at (1000,1000) -> top bounce on play tick 48: ball (256,25), vy becomes +2. Right wall at play tick 68, y=65 outside window: ball (294,65), vx=-2, no goal.
- p1 at (200,120), first play tick -> dist_sq 1600 hit: vx=-2, vy=+2, ball (158,122).
- GOAL_Y_MIN=0, GOAL_Y_MAX=239, players off-field -> play tick 68 ball (294,65), goal pulse, score_p1=1. After 30 ticks -> ball (160,120), vx=+2.
- Same as previous with WIN_SCORE=1 -> game_over=1 after the goal; further ticks change nothing.
- rst=0 during HIT_P2 -> next edge ball (160,120), scores 0, no update_done.

Source files
------------

// File: rtl/ball_engine.sv
// ball_engine -- game-state stage that feeds the VGA compositor.
//
// Advances the ball once per frame tick, resolves wall, player and goal
// collisions and keeps score. All coordinates are 320x240 half-resolution
// pixels, referenced to the ball centre.
//
// Optional feature macro: SPEEDUP_EN
//   defined   : each player hit raises the per-axis speed by 1, saturating
//               at 2*SPEED; the speed returns to SPEED on every serve.
//   undefined : the per-axis speed is always SPEED.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active low
//   frame_tick   in   one-cycle pulse per video frame
//   p1_x/p1_y    in   player 1 centre (16b each)
//   p2_x/p2_y    in   player 2 centre (16b each)
//   ball_x/y     out  ball centre, registered (16b each)
//   score_p1/p2  out  scores (4b each), saturate at WIN_SCORE
//   goal         out  one-cycle pulse when a goal is scored
//   update_done  out  one-cycle pulse after each position write
//   game_over    out  level, high once a score reaches WIN_SCORE
module ball_engine #(
  parameter int FIELD_W      = 320,
  parameter int FIELD_H      = 240,
  parameter int BALL_R       = 25,
  parameter int HIT_DIST_SQ  = 2809,
  parameter int SPEED        = 2,
  parameter int GOAL_Y_MIN   = 80,
  parameter int GOAL_Y_MAX   = 160,
  parameter int SERVE_FRAMES = 60,
  parameter int GOAL_FRAMES  = 30,
  parameter int WIN_SCORE    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [15:0] p1_x,
  input  logic [15:0] p1_y,
  input  logic [15:0] p2_x,
  input  logic [15:0] p2_y,
  output logic [15:0] ball_x,
  output logic [15:0] ball_y,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        goal,
  output logic        update_done,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_SERVE, S_WAIT, S_HIT_P1, S_HIT_P2, S_MOVE, S_GOAL, S_OVER
  } state_t;

  localparam logic [15:0]        CX    = 16'(FIELD_W / 2);
  localparam logic [15:0]        CY    = 16'(FIELD_H / 2);
  localparam logic signed [17:0] LIM_LO = 18'(BALL_R);
  localparam logic signed [17:0] LIM_XH = 18'(FIELD_W - 1 - BALL_R);
  localparam logic signed [17:0] LIM_YH = 18'(FIELD_H - 1 - BALL_R);

  state_t      r_state;
  logic [15:0] r_ball_x, r_ball_y;
  logic [15:0] r_mag;          // per-axis speed magnitude
  logic        r_vx_neg, r_vy_neg;
  logic [15:0] r_cnt;          // tick counter for SERVE / GOAL holds
  logic        r_hit1;
  logic        r_p1_scored;    // who scored last, picks the serve direction
  logic [3:0]  r_score_p1, r_score_p2;
  logic        r_goal, r_update_done, r_game_over;

  // Hit test: 17-bit signed deltas, squared distance summed unsigned at 34b.
  function automatic logic f_hit(input logic [15:0] bx, by, px, py);
    logic signed [16:0] dx, dy;
    logic signed [33:0] ex, ey;
    logic [33:0]        sq;
    dx = $signed({1'b0, bx}) - $signed({1'b0, px});
    dy = $signed({1'b0, by}) - $signed({1'b0, py});
    ex = 34'(dx);
    ey = 34'(dy);
    sq = $unsigned(ex * ex) + $unsigned(ey * ey);
    return sq <= 34'(HIT_DIST_SQ);
  endfunction

  logic        w_hit1, w_hit2, w_any_hit;
  logic [15:0] w_px, w_py, w_mag_hit;
  assign w_hit1    = f_hit(r_ball_x, r_ball_y, p1_x, p1_y);
  assign w_hit2    = f_hit(r_ball_x, r_ball_y, p2_x, p2_y);
  assign w_any_hit = r_hit1 | w_hit2;
  // p1 takes priority when both players touch the ball
  assign w_px      = r_hit1 ? p1_x : p2_x;
  assign w_py      = r_hit1 ? p1_y : p2_y;

`ifdef SPEEDUP_EN
  assign w_mag_hit = (r_mag < 16'(2 * SPEED)) ? r_mag + 16'd1 : r_mag;
`else
  assign w_mag_hit = r_mag;
`endif

  // Candidate position and wall/goal resolution for the MOVE state.
  logic signed [17:0] w_mag_s, w_vx, w_vy, w_nx, w_ny;
  logic [15:0]        w_cx, w_cy;
  logic               w_vx_neg_n, w_vy_neg_n, w_in_mouth, w_goal_p1, w_goal_p2;

  assign w_mag_s = $signed({2'b00, r_mag});
  assign w_vx    = r_vx_neg ? -w_mag_s : w_mag_s;
  assign w_vy    = r_vy_neg ? -w_mag_s : w_mag_s;
  assign w_nx    = $signed({2'b00, r_ball_x}) + w_vx;
  assign w_ny    = $signed({2'b00, r_ball_y}) + w_vy;

  always_comb begin
    w_cx       = w_nx[15:0];
    w_cy       = w_ny[15:0];
    w_vx_neg_n = r_vx_neg;
    w_vy_neg_n = r_vy_neg;
    w_goal_p1  = 1'b0;
    w_goal_p2  = 1'b0;
    if (w_ny < LIM_LO) begin
      w_cy       = LIM_LO[15:0];
      w_vy_neg_n = 1'b0;
    end else if (w_ny > LIM_YH) begin
      w_cy       = LIM_YH[15:0];
      w_vy_neg_n = 1'b1;
    end
    // goal mouth is judged on the already-clamped y
    w_in_mouth = (w_cy >= 16'(GOAL_Y_MIN)) && (w_cy <= 16'(GOAL_Y_MAX));
    if (w_nx < LIM_LO) begin
      w_cx = LIM_LO[15:0];
      if (w_in_mouth) w_goal_p2  = 1'b1;
      else            w_vx_neg_n = 1'b0;
    end else if (w_nx > LIM_XH) begin
      w_cx = LIM_XH[15:0];
      if (w_in_mouth) w_goal_p1  = 1'b1;
      else            w_vx_neg_n = 1'b1;
    end
  end

  logic [3:0] w_s1_inc, w_s2_inc;
  assign w_s1_inc = (r_score_p1 < 4'(WIN_SCORE)) ? r_score_p1 + 4'd1 : r_score_p1;
  assign w_s2_inc = (r_score_p2 < 4'(WIN_SCORE)) ? r_score_p2 + 4'd1 : r_score_p2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_SERVE;
      r_ball_x      <= CX;
      r_ball_y      <= CY;
      r_mag         <= 16'(SPEED);
      r_vx_neg      <= 1'b0;
      r_vy_neg      <= 1'b1;
      r_cnt         <= '0;
      r_hit1        <= 1'b0;
      r_p1_scored   <= 1'b0;
      r_score_p1    <= '0;
      r_score_p2    <= '0;
      r_goal        <= 1'b0;
      r_update_done <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_goal        <= 1'b0;
      r_update_done <= 1'b0;
      case (r_state)
        S_SERVE: if (frame_tick) begin
          if (r_cnt == 16'(SERVE_FRAMES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WAIT: if (frame_tick) r_state <= S_HIT_P1;
        S_HIT_P1: begin
          r_hit1  <= w_hit1;
          r_state <= S_HIT_P2;
        end
        S_HIT_P2: begin
          if (w_any_hit) begin
            r_vx_neg <= r_ball_x < w_px;
            r_vy_neg <= r_ball_y < w_py;
            r_mag    <= w_mag_hit;
          end
          r_state <= S_MOVE;
        end
        S_MOVE: begin
          r_ball_x      <= w_cx;
          r_ball_y      <= w_cy;
          r_vx_neg      <= w_vx_neg_n;
          r_vy_neg      <= w_vy_neg_n;
          r_update_done <= 1'b1;
          if (w_goal_p1) begin
            r_score_p1  <= w_s1_inc;
            r_goal      <= 1'b1;
            r_p1_scored <= 1'b1;
            if (w_s1_inc == 4'(WIN_SCORE)) begin
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_state <= S_GOAL;
            end
          end else if (w_goal_p2) begin
            r_score_p2  <= w_s2_inc;
            r_goal      <= 1'b1;
            r_p1_scored <= 1'b0;
            if (w_s2_inc == 4'(WIN_SCORE)) begin
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_state <= S_GOAL;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_GOAL: if (frame_tick) begin
          if (r_cnt == 16'(GOAL_FRAMES - 1)) begin
            // re-centre and serve toward the side that conceded
            r_cnt    <= '0;
            r_ball_x <= CX;
            r_ball_y <= CY;
            r_vx_neg <= ~r_p1_scored;
            r_vy_neg <= 1'b1;
            r_mag    <= 16'(SPEED);
            r_state  <= S_SERVE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_OVER: ;
        default: r_state <= S_SERVE;
      endcase
    end
  end

  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign score_p1    = r_score_p1;
  assign score_p2    = r_score_p2;
  assign goal        = r_goal;
  assign update_done = r_update_done;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_ball_engine.sv
module tb_ball_engine;

  logic        clk = 1'b0;
  logic        rst, frame_tick;
  logic [15:0] p1_x, p1_y, p2_x, p2_y;

  // u0: default build; u1: full-height goal mouth; u2: full mouth, first goal wins
  logic [15:0] bx0, by0, bx1, by1, bx2, by2;
  logic [3:0]  s1_0, s2_0, s1_1, s2_1, s1_2, s2_2;
  logic        g0, ud0, go0, g1, ud1, go1, g2, ud2, go2;

  int n_vec = 0;
  int n_bad = 0;
  int ud_cnt0 = 0, ud_cnt2 = 0, g_cnt2 = 0;

  always #5 clk = ~clk;

  ball_engine u0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .ball_x(bx0), .ball_y(by0), .score_p1(s1_0), .score_p2(s2_0),
    .goal(g0), .update_done(ud0), .game_over(go0));

  ball_engine #(.GOAL_Y_MIN(0), .GOAL_Y_MAX(239)) u1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .ball_x(bx1), .ball_y(by1), .score_p1(s1_1), .score_p2(s2_1),
    .goal(g1), .update_done(ud1), .game_over(go1));

  ball_engine #(.GOAL_Y_MIN(0), .GOAL_Y_MAX(239), .WIN_SCORE(1)) u2 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .ball_x(bx2), .ball_y(by2), .score_p1(s1_2), .score_p2(s2_2),
    .goal(g2), .update_done(ud2), .game_over(go2));

  always @(posedge clk) begin
    if (ud0) ud_cnt0 <= ud_cnt0 + 1;
    if (ud2) ud_cnt2 <= ud_cnt2 + 1;
    if (g2)  g_cnt2  <= g_cnt2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulse a tick and return at the negedge following the 3rd edge after the
  // sampling edge, i.e. where a fresh update is first visible.
  task automatic tick_n4();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick();
    tick_n4();
    repeat (2) @(negedge clk);
  endtask

  task automatic players_far();
    p1_x = 16'd1000; p1_y = 16'd1000; p2_x = 16'd1000; p2_y = 16'd1000;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b0; frame_tick = 1'b0;
    players_far();
    repeat (3) @(negedge clk);
    chk("rst_bx", 32'(bx0), 32'd160);
    chk("rst_by", 32'(by0), 32'd120);
    chk("rst_scores", 32'({s1_0, s2_0}), 32'd0);
    chk("rst_flags", 32'({g0, ud0, go0}), 32'd0);
    rst = 1'b1;

    // serve hold: 60 ticks, no movement, no update pulse
    base = ud_cnt0;
    repeat (60) tick();
    chk("serve_ud", 32'(ud_cnt0 - base), 32'd0);
    chk("serve_ball", 32'({bx0, by0}), {16'd160, 16'd120});

    // first play tick: exact 3-edge latency, one-cycle update_done
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    chk("lat_early_ball", 32'({bx0, by0}), {16'd160, 16'd120});
    chk("lat_early_ud", 32'(ud0), 32'd0);
    @(negedge clk);
    chk("lat_ball", 32'({bx0, by0}), {16'd162, 16'd118});
    chk("lat_ud", 32'(ud0), 32'd1);
    @(negedge clk);
    chk("ud_pulse", 32'(ud0), 32'd0);

    // play ticks 2..47, then top bounce on 48
    for (int k = 2; k <= 47; k++) tick();
    tick_n4();
    chk("top_bounce", 32'({bx0, by0}), {16'd256, 16'd25});
    repeat (2) @(negedge clk);
    tick_n4();
    chk("top_vy_pos", 32'({bx0, by0}), {16'd258, 16'd27});
    repeat (2) @(negedge clk);
    for (int k = 50; k <= 67; k++) tick();

    // tick 68: right wall, outside default mouth; goal for wide-mouth builds
    base = ud_cnt2;
    tick_n4();
    chk("right_wall", 32'({bx0, by0}), {16'd294, 16'd65});
    chk("right_nogoal", 32'({g0, s1_0}), 32'd0);
    chk("goal_ball", 32'({bx1, by1}), {16'd294, 16'd65});
    chk("goal_pulse", 32'({g1, ud1}), 32'b11);
    chk("goal_score", 32'({s1_1, s2_1}), {24'd0, 4'd1, 4'd0});
    chk("win_over", 32'({go2, s1_2}), {27'd0, 1'b1, 4'd1});
    chk("goal_nowin", 32'(go1), 32'd0);
    @(negedge clk);
    chk("goal_1cyc", 32'(g1), 32'd0);
    @(negedge clk);
    base = ud_cnt2;

    // tick 69: default build bounced off the right wall; goal build frozen
    tick_n4();
    chk("right_vx_neg", 32'({bx0, by0}), {16'd292, 16'd67});
    chk("goal_frozen", 32'({bx1, by1}), {16'd294, 16'd65});
    chk("goal_frozen_ud", 32'(ud1), 32'd0);
    repeat (2) @(negedge clk);
    for (int k = 70; k <= 97; k++) tick();
    chk("goal_hold29", 32'({bx1, by1}), {16'd294, 16'd65});
    tick();
    chk("goal_recentre", 32'({bx1, by1}), {16'd160, 16'd120});
    repeat (60) tick();
    tick_n4();
    chk("reserve_dir", 32'({bx1, by1}), {16'd162, 16'd118});
    repeat (2) @(negedge clk);
    chk("over_frozen", 32'({bx2, by2}), {16'd294, 16'd65});
    chk("over_state", 32'({go2, s1_2, s2_2}), {23'd0, 1'b1, 4'd1, 4'd0});
    chk("over_no_pulse", 32'(ud_cnt2 - base + g_cnt2), 32'd1);

    // reset asserted while in HIT_P2
    do_reset();
    repeat (60) tick();
    base = ud_cnt0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ball", 32'({bx0, by0}), {16'd160, 16'd120});
    chk("mid_rst_scores", 32'({s1_1, s2_1, s1_2}), 32'd0);
    chk("mid_rst_over", 32'(go2), 32'd0);
    @(negedge clk);
    chk("mid_rst_ud", 32'(ud_cnt0 - base), 32'd0);
    rst = 1'b1;

    // hits: both players exactly at the hit distance, p1 takes priority
    do_reset();
    repeat (60) tick();
    p1_x = 16'd213; p1_y = 16'd120; p2_x = 16'd107; p2_y = 16'd120;
    tick_n4();
    chk("hit_p1_prio", 32'({bx0, by0}), {16'd158, 16'd122});
    repeat (2) @(negedge clk);
    // p2 alone, dist_sq 1448
    p1_x = 16'd1000; p1_y = 16'd1000; p2_x = 16'd120; p2_y = 16'd120;
    tick_n4();
    chk("hit_p2", 32'({bx0, by0}), {16'd160, 16'd124});
    repeat (2) @(negedge clk);
    // p1 one pixel beyond hit distance (dist_sq 2916): no deflection
    p1_x = 16'd214; p1_y = 16'd124; p2_x = 16'd1000; p2_y = 16'd1000;
    tick_n4();
    chk("miss_edge", 32'({bx0, by0}), {16'd162, 16'd126});
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
